fifo_top: RTL and testbench

Synchronous first-in/first-out buffer: a `depth`-entry, `data_width`-bit RAM with write and read pointers and full/empty flags. It is the storage stage between a producer that pushes with `w_en` and a consumer that pops with `r_en`, both on the same clock. Pointer and address values are exported so a bench can trace occupancy and wrap-around.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 48 ++++
 rtl/fifo_top.sv | 92 +++++++++
 tb/tb_fifo_top.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Default sizing constants and pointer type for the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   localparam int DEPTH      = 256;
   localparam int DATA_WIDTH = 8;
   localparam int PTR_WIDTH  = 8;

   // Binary pointer: address bits plus one wrap bit
   typedef logic [PTR_WIDTH:0] ptr_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : Simple dual-port RAM, synchronous write port and registered
//               synchronous read port. Read register clears on reset; the
//               storage array itself is never cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int depth      = DEPTH,
   parameter int data_width = DATA_WIDTH,
   parameter int ptr_width  = PTR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [ptr_width-1:0]  i_waddr,
   input  logic [data_width-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ptr_width-1:0]  i_raddr,
   output logic [data_width-1:0] o_rdata
);

   logic [data_width-1:0] r_mem [depth];
   logic [data_width-1:0] r_rdata;

   // Write port: store data at the write address when enabled
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: registered output, holds its value when no read is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_top.sv
`default_nettype none
// ============================================================================
// Module      : fifo_top
// Description : Single-clock FIFO. Binary write/read pointers with an extra
//               wrap bit, combinational full/empty flags from the registered
//               pointers, and accept gating in front of a dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_top
   import fifo_pkg::*;
#(
   parameter int depth      = DEPTH,
   parameter int data_width = DATA_WIDTH,
   parameter int ptr_width  = PTR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [data_width-1:0] data_in,
   input  logic                  r_en,
   output logic [data_width-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic [ptr_width:0]    wptr,
   output logic [ptr_width:0]    rptr,
   output logic [ptr_width-1:0]  waddr,
   output logic [ptr_width-1:0]  raddr,
   output logic [ptr_width:0]    count
);

   localparam logic [ptr_width:0] c_ptr_one = 1;

   logic [ptr_width:0] r_wptr;
   logic [ptr_width:0] r_rptr;
   logic               w_full;
   logic               w_empty;
   logic               w_wr_acc;
   logic               w_rd_acc;

   // Flags come from the pre-edge pointers, so there is no write-through:
   // a simultaneous request on an empty FIFO only writes, on a full one only reads.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ptr_width] != r_rptr[ptr_width]) &&
                    (r_wptr[ptr_width-1:0] == r_rptr[ptr_width-1:0]);

   // Reset outranks any request on the same edge
   assign w_wr_acc = w_en && !w_full  && !rst;
   assign w_rd_acc = r_en && !w_empty && !rst;

   // Write pointer advances on each accepted write
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
      end else if (w_wr_acc) begin
         r_wptr <= r_wptr + c_ptr_one;
      end
   end

   // Read pointer advances on each accepted read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rptr <= '0;
      end else if (w_rd_acc) begin
         r_rptr <= r_rptr + c_ptr_one;
      end
   end

   fifo_mem #(
      .depth      (depth),
      .data_width (data_width),
      .ptr_width  (ptr_width)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr[ptr_width-1:0]),
      .i_wdata (data_in),
      .i_re    (w_rd_acc),
      .i_raddr (r_rptr[ptr_width-1:0]),
      .o_rdata (data_out)
   );

   assign full  = w_full;
   assign empty = w_empty;
   assign wptr  = r_wptr;
   assign rptr  = r_rptr;
   assign waddr = r_wptr[ptr_width-1:0];
   assign raddr = r_rptr[ptr_width-1:0];
   assign count = r_wptr - r_rptr;

endmodule : fifo_top
`default_nettype wire

// File: tb/tb_fifo_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_top
// Description : Directed self-checking bench for fifo_top (default sizing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_top;

   logic       clk;
   logic       rst;
   logic       w_en;
   logic [7:0] data_in;
   logic       r_en;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic [8:0] wptr;
   logic [8:0] rptr;
   logic [7:0] waddr;
   logic [7:0] raddr;
   logic [8:0] count;

   int         n_cmp;
   int         n_err;
   logic [7:0] q[$];
   logic [7:0] exp_d;

   fifo_top dut (
      .clk      (clk),
      .rst      (rst),
      .w_en     (w_en),
      .data_in  (data_in),
      .r_en     (r_en),
      .data_out (data_out),
      .full     (full),
      .empty    (empty),
      .wptr     (wptr),
      .rptr     (rptr),
      .waddr    (waddr),
      .raddr    (raddr),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: n accepted writes of random data, mirrored in the queue
   task automatic push_only(input int n);
      w_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         data_in = 8'($urandom);
         q.push_back(data_in);
         tick();
      end
      w_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
      n_cmp++; if (count !== 9'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (wptr !== 9'd0 || rptr !== 9'd0) begin n_err++; $display("FAIL reset_ptrs: got w=%0d r=%0d want 0/0", wptr, rptr); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %0h want 0", data_out); end
   endtask

   task automatic test_fill();
      push_only(256);
      n_cmp++; if (wptr !== 9'h100) begin n_err++; $display("FAIL fill_wptr: got %0h want 100", wptr); end
      n_cmp++; if (waddr !== 8'd0) begin n_err++; $display("FAIL fill_waddr: got %0d want 0", waddr); end
      n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_err++; $display("FAIL fill_flags: got full=%b empty=%b want 1/0", full, empty); end
      n_cmp++; if (count !== 9'd256) begin n_err++; $display("FAIL fill_count: got %0d want 256", count); end
      w_en = 1'b1; data_in = 8'hA5; tick(); w_en = 1'b0;
      n_cmp++; if (wptr !== 9'h100) begin n_err++; $display("FAIL fill_overflow_wptr: got %0h want 100", wptr); end
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_overflow_full: got %b want 1", full); end
   endtask

   task automatic test_drain();
      r_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick();
         exp_d = q.pop_front();
         n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, data_out, exp_d); end
      end
      r_en = 1'b0;
      n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL drain_flags: got empty=%b full=%b want 1/0", empty, full); end
      n_cmp++; if (rptr !== 9'h100) begin n_err++; $display("FAIL drain_rptr: got %0h want 100", rptr); end
      r_en = 1'b1; tick(); r_en = 1'b0;
      n_cmp++; if (rptr !== 9'h100) begin n_err++; $display("FAIL underflow_rptr: got %0h want 100", rptr); end
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL underflow_dout: got %0h want %0h", data_out, exp_d); end
   endtask

   task automatic test_wrap();
      logic [7:0] prev;
      logic       wrapped;
      push_only(200);
      r_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         exp_d = q.pop_front();
         n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL wrap_rd1[%0d]: got %0h want %0h", i, data_out, exp_d); end
      end
      r_en = 1'b0;
      wrapped = 1'b0;
      prev = waddr;
      w_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         data_in = 8'($urandom);
         q.push_back(data_in);
         tick();
         if (prev == 8'd255 && waddr == 8'd0) wrapped = 1'b1;
         prev = waddr;
      end
      w_en = 1'b0;
      n_cmp++; if (wrapped !== 1'b1) begin n_err++; $display("FAIL wrap_waddr_seen: got %b want 1", wrapped); end
      n_cmp++; if (count !== 9'd100) begin n_err++; $display("FAIL wrap_count: got %0d want 100", count); end
      n_cmp++; if (waddr !== 8'd44 || wptr !== 9'd44) begin n_err++; $display("FAIL wrap_wptr: got waddr=%0d wptr=%0d want 44/44", waddr, wptr); end
      r_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         exp_d = q.pop_front();
         n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL wrap_rd2[%0d]: got %0h want %0h", i, data_out, exp_d); end
      end
      r_en = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", empty); end
   endtask

   task automatic test_concurrent();
      push_only(10);
      w_en = 1'b1; r_en = 1'b1;
      for (int i = 0; i < 50; i++) begin
         data_in = 8'($urandom);
         q.push_back(data_in);
         tick();
         exp_d = q.pop_front();
         n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL conc_data[%0d]: got %0h want %0h", i, data_out, exp_d); end
         n_cmp++; if (count !== 9'd10) begin n_err++; $display("FAIL conc_count[%0d]: got %0d want 10", i, count); end
      end
      w_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         exp_d = q.pop_front();
         n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL conc_tail[%0d]: got %0h want %0h", i, data_out, exp_d); end
      end
      r_en = 1'b0;
      n_cmp++; if (empty !== 1'b1 || count !== 9'd0) begin n_err++; $display("FAIL conc_end: got empty=%b count=%0d want 1/0", empty, count); end
   endtask

   task automatic test_back_to_back_edges();
      // Simultaneous requests while full: only the read is taken
      push_only(256);
      w_en = 1'b1; r_en = 1'b1; data_in = 8'h55; tick(); w_en = 1'b0; r_en = 1'b0;
      exp_d = q.pop_front();
      n_cmp++; if (count !== 9'd255) begin n_err++; $display("FAIL full_simul_count: got %0d want 255", count); end
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL full_simul_data: got %0h want %0h", data_out, exp_d); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_simul_flag: got %b want 0", full); end
      r_en = 1'b1;
      for (int i = 0; i < 255; i++) begin
         tick();
         exp_d = q.pop_front();
         n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL full_simul_drain[%0d]: got %0h want %0h", i, data_out, exp_d); end
      end
      r_en = 1'b0;
      // Simultaneous requests while empty: only the write is taken
      w_en = 1'b1; r_en = 1'b1; data_in = 8'h3C; q.push_back(data_in); tick(); w_en = 1'b0; r_en = 1'b0;
      n_cmp++; if (count !== 9'd1) begin n_err++; $display("FAIL empty_simul_count: got %0d want 1", count); end
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL empty_simul_hold: got %0h want %0h", data_out, exp_d); end
      r_en = 1'b1; tick(); r_en = 1'b0;
      exp_d = q.pop_front();
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL empty_simul_data: got %0h want %0h", data_out, exp_d); end
   endtask

   task automatic test_mid_reset();
      push_only(37);
      n_cmp++; if (count !== 9'd37) begin n_err++; $display("FAIL midrst_pre_count: got %0d want 37", count); end
      rst = 1'b1; w_en = 1'b1; data_in = 8'hEE; tick(); rst = 1'b0; w_en = 1'b0;
      q.delete();
      n_cmp++; if (count !== 9'd0 || empty !== 1'b1) begin n_err++; $display("FAIL midrst_state: got count=%0d empty=%b want 0/1", count, empty); end
      n_cmp++; if (wptr !== 9'd0 || rptr !== 9'd0) begin n_err++; $display("FAIL midrst_ptrs: got w=%0d r=%0d want 0/0", wptr, rptr); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL midrst_dout: got %0h want 0", data_out); end
      r_en = 1'b1; tick(); r_en = 1'b0;
      n_cmp++; if (data_out !== 8'h00 || rptr !== 9'd0) begin n_err++; $display("FAIL midrst_no_store: got dout=%0h rptr=%0d want 0/0", data_out, rptr); end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b0;
      w_en    = 1'b0;
      r_en    = 1'b0;
      data_in = 8'h00;
      exp_d   = 8'h00;
      #2;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_concurrent();
      test_back_to_back_edges();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fifo_top
`default_nettype wire
